// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: ALU control codes,
// ALUOp encodings, R-type funct values and the ALU-control decoder.
package operand_fetch_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_NOR  = 4'b1100,
    ALU_NONE = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_NONE  = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  // Unknown funct and ALUOp 11 both map to ALU_NONE (ALU yields zero).
  function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [5:0] funct);
    logic [3:0] ctrl;
    ctrl = ALU_NONE;
    case (alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl = ALU_ADD;
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_SLT: ctrl = ALU_SLT;
          FUNCT_NOR: ctrl = ALU_NOR;
          default:   ctrl = ALU_NONE;
        endcase
      end
      default: ctrl = ALU_NONE;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, register 0 hardwired to zero, asynchronous active-low clear.
module operand_fetch_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];

  // Writeback port; writes to register 0 are dropped so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read ports; register 0 forced to zero independent of storage.
  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage ahead of the ALU. Reads A/B from the register file
// (B optionally from the sign-extended immediate), decodes ALUOp/funct and
// presents registered operands behind a valid/ready handshake.
// Optional macro OPERAND_BYPASS_EN: forwards a same-cycle writeback into
// the captured operands; without it the pre-write register value is taken.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [15:0]       imm,
  input  logic              alu_src,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control
);

  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] a_d, b_d, rt_val;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [3:0]        alu_control_q;
  logic              out_valid_q;
  logic              accept;

  operand_fetch_reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand selection, with optional write-through of a same-cycle writeback.
  always_comb begin
`ifdef OPERAND_BYPASS_EN
    a_d    = (wr_en && (wr_addr == rs) && (wr_addr != '0)) ? wr_data : rd_a;
    rt_val = (wr_en && (wr_addr == rt) && (wr_addr != '0)) ? wr_data : rd_b;
`else
    a_d    = rd_a;
    rt_val = rd_b;
`endif
    b_d = alu_src ? {{(DATA_W-16){imm[15]}}, imm} : rt_val;
  end

  // Output register: load on accept, drop valid once consumed, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= 4'b0000;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      alu_a_q       <= a_d;
      alu_b_q       <= b_d;
      alu_control_q <= alu_decode(alu_op, funct);
    end else if (out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_control_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with hand-computed expectations.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .funct       (funct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [4:0] r_s, input logic [4:0] r_t, input logic [15:0] im,
                       input logic src, input logic [1:0] op, input logic [5:0] fn);
    in_valid = 1'b1;
    rs = r_s; rt = r_t; imm = im; alu_src = src; alu_op = op; funct = fn;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  logic [1:0]  dec_op [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
  logic [5:0]  dec_fn [6] = '{6'b100100, 6'b100101, 6'b100111, 6'b000000, 6'b100000, 6'b100000};
  logic [3:0]  dec_ex [6] = '{4'b0000, 4'b0001, 4'b1100, 4'b1111, 4'b1111, 4'b0110};
  logic [31:0] exp_same;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    in_valid = 1'b0; rs = '0; rt = '0; imm = '0; alu_src = 1'b0;
    alu_op = '0; funct = '0; out_ready = 1'b1;
    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_ctrl", {28'b0, alu_control}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    step(); step();
    rst_n = 1'b1;
    step();

    // zero registers, R-type add
    instr(5'd3, 5'd4, 16'h0, 1'b0, 2'b10, 6'b100000);
    step();
    in_valid = 1'b0;
    chk("t1_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_a", alu_a, 32'd0);
    chk("t1_b", alu_b, 32'd0);
    chk("t1_ctrl", {28'b0, alu_control}, 32'h2);

    wr(5'd5, 32'h10);
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_hold_ctrl", {28'b0, alu_control}, 32'h2);
    wr(5'd6, 32'h3);
    wr(5'd8, 32'hA1);
    wr(5'd9, 32'hB2);

    // slt r5, r6
    instr(5'd5, 5'd6, 16'h0, 1'b0, 2'b10, 6'b101010);
    step();
    chk("t2_a", alu_a, 32'h10);
    chk("t2_b", alu_b, 32'h3);
    chk("t2_ctrl", {28'b0, alu_control}, 32'h7);

    // immediate, back-to-back with the previous accept
    instr(5'd5, 5'd6, 16'hFFFE, 1'b1, 2'b00, 6'b000000);
    step();
    chk("t3_valid", {31'b0, out_valid}, 32'd1);
    chk("t3_a", alu_a, 32'h10);
    chk("t3_b", alu_b, 32'hFFFF_FFFE);
    chk("t3_ctrl", {28'b0, alu_control}, 32'h2);
    in_valid = 1'b0;

    // register 0 ignores writes
    wr(5'd0, 32'hDEAD_BEEF);
    instr(5'd0, 5'd0, 16'h0, 1'b0, 2'b01, 6'b000000);
    step();
    chk("r0_a", alu_a, 32'd0);
    chk("r0_b", alu_b, 32'd0);
    chk("r0_ctrl", {28'b0, alu_control}, 32'h6);

    // decode table, back-to-back accepts
    for (int i = 0; i < 6; i++) begin
      instr(5'd6, 5'd5, 16'h0, 1'b0, dec_op[i], dec_fn[i]);
      step();
      chk($sformatf("dec%0d_ctrl", i), {28'b0, alu_control}, {28'b0, dec_ex[i]});
    end
    chk("dec_b", alu_b, 32'h10);
    in_valid = 1'b0;
    step();

    // backpressure: X stalls, Y waits then goes through exactly once
    out_ready = 1'b0;
    instr(5'd8, 5'd0, 16'h0, 1'b0, 2'b00, 6'b000000);
    step();
    chk("bp_x_a", alu_a, 32'hA1);
    instr(5'd9, 5'd0, 16'h0, 1'b0, 2'b01, 6'b000000);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
      chk($sformatf("bp%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_a", i), alu_a, 32'hA1);
      chk($sformatf("bp%0d_ctrl", i), {28'b0, alu_control}, 32'h2);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_up", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_y_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_y_a", alu_a, 32'hB2);
    chk("bp_y_ctrl", {28'b0, alu_control}, 32'h6);
    step();
    chk("bp_no_dup", {31'b0, out_valid}, 32'd0);
    chk("bp_hold_a", alu_a, 32'hB2);

    // same-cycle writeback and accept on r7
    wr(5'd7, 32'h11);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    instr(5'd7, 5'd7, 16'h0, 1'b0, 2'b00, 6'b000000);
    step();
    wr_en = 1'b0;
`ifdef OPERAND_BYPASS_EN
    exp_same = 32'h55;
`else
    exp_same = 32'h11;
`endif
    chk("fwd_a", alu_a, exp_same);
    chk("fwd_b", alu_b, exp_same);
    step();
    chk("after_wr_a", alu_a, 32'h55);

    // snapshot: stalled output unaffected by later write to rs
    out_ready = 1'b0;
    in_valid = 1'b0;
    wr(5'd7, 32'h99);
    chk("snap_a", alu_a, 32'h55);
    chk("snap_valid", {31'b0, out_valid}, 32'd1);

    // reset while stalled clears output and register contents
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_a", alu_a, 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    instr(5'd5, 5'd7, 16'h0, 1'b0, 2'b00, 6'b000000);
    step();
    in_valid = 1'b0;
    chk("post_rst_a", alu_a, 32'd0);
    chk("post_rst_b", alu_b, 32'd0);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage directly upstream of the ALU: holds the architectural register file and decodes ALUOp/funct into the ALU's 4-bit control code.
- Accepts one decoded instruction per handshake and presents registered A, B and control to the ALU one cycle later.
- Writeback from the end of the datapath enters through a dedicated write port.

Parameters:
- DATA_W, 32, register and operand width.
- ADDR_W, 5, register index width; register count is 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback register index
- wr_data  in  DATA_W  writeback value
- in_valid  in  1  instruction fields valid
- in_ready  out  1  stage can accept
- rs  in  ADDR_W  source register for A
- rt  in  ADDR_W  source register for B
- imm  in  16  immediate field
- alu_src  in  1  1 = B from sign-extended imm, 0 = B from rf[rt]
- alu_op  in  2  main-decoder ALUOp
- funct  in  6  R-type function field
- out_valid  out  1  operands valid to ALU
- out_ready  in  1  consumer accepts
- alu_a  out  DATA_W  operand A
- alu_b  out  DATA_W  operand B
- alu_control  out  4  ALU operation code

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low. Reset clears all registers to 0, alu_a/alu_b to 0, alu_control to 4'b0000 and out_valid to 0.
- Register 0 always reads 0. Writes to register 0 are discarded.
- Writeback: rf[wr_addr] <= wr_data on the clk edge when wr_en=1. The write is independent of the handshake and is never stalled.
- in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready.
- On accept, at the next edge:
  - alu_a <= rf[rs]
  - alu_b <= alu_src ? {{16{imm[15]}}, imm} : rf[rt]
  - alu_control <= decode
  - out_valid <= 1
- Latency is one cycle.
- If out_valid && out_ready && !accept, out_valid <= 0 and the outputs hold their last values.
- While out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Operands are snapshots taken at accept. A later writeback to rs/rt does not alter outputs already presented.
- Decode:
  - alu_op 00 -> 0010 (add)
  - alu_op 01 -> 0110 (sub)
  - alu_op 10 uses funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100; any other funct -> 1111, which the ALU maps to a zero result.
  - alu_op 11 -> 1111.
- Same-cycle writeback and accept reading the same register (not register 0): the captured value is the pre-write value, unless the optional feature is enabled.
- Reset asserted mid-transfer drops the pending output (out_valid=0) immediately.

Optional Feature:
- Macro: OPERAND_BYPASS_EN.
- Defined: on a same-cycle wr_en with wr_addr == rs (or == rt when alu_src=0) and wr_addr != 0, the captured operand is wr_data (write-through forwarding).
- Undefined: the captured operand is the old register contents, and the bench must expect the stale value.

Decomposition:
- Shared package holds:
  - ALU control codes: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100, ALU_NONE=4'b1111.
  - ALUOp encodings.
  - funct constants.
- One sub-module, reg_file: two async-read ports, one sync write port, register 0 hardwired, async active-low clear.
- Decode and handshake stay in operand_fetch.

Test Plan:
- Reset then accept rs=3, rt=4 (both 0), alu_op=10, funct=100000 -> next cycle out_valid=1, alu_a=0, alu_b=0, alu_control=0010.
- Write r5=0x0000_0010 and r6=0x0000_0003, then accept rs=5, rt=6, alu_op=10, funct=101010 -> alu_a=0x10, alu_b=0x3, alu_control=0111.
- Accept alu_src=1, imm=16'hFFFE, alu_op=00 -> alu_b=0xFFFF_FFFE, alu_control=0010.
- Write r0=0xDEAD_BEEF, then read rs=0 -> alu_a=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; raise out_ready -> next instruction appears the following cycle with no loss or duplication.
- Same-cycle write r7=0x55 (old value 0x11) and accept rs=7 -> alu_a=0x11 without OPERAND_BYPASS_EN, 0x55 with it.
